divider_arbiter: RTL
====================

Name: divider_arbiter

Overview:
- Shares one external `divider` instance (restoring, N_BITS-cycle iterative) between N_REQ requesters, e.g. per-lane perspective/slope divides in the raster pipeline.
- Per-requester valid/ready request channels; round-robin arbitration; drives the divider's start/operand ports; returns quotient/remainder on a shared response bus with a one-hot valid.
- Sits between the raster lanes and the single shared divider.

Parameters:
- N_BITS, 8, operand/result width; must match the attached divider.
- N_REQ, 4, number of requesters, 2..16.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept, one-hot or zero.
- req_numerator  in  N_REQ*N_BITS  packed; requester i at [i*N_BITS +: N_BITS].
- req_denominator  in  N_REQ*N_BITS  packed, same layout.
- req_signed  in  N_REQ  numerator-signed flag per requester.
- rsp_valid  out  N_REQ  one-hot response valid.
- rsp_ready  in  N_REQ  per-requester response accept.
- rsp_quotient  out  N_BITS  result quotient.
- rsp_remainder  out  N_BITS  result remainder.
- div_start  out  1  to divider start.
- div_numerator  out  N_BITS  to divider numerator.
- div_denominator  out  N_BITS  to divider denominator.
- div_numerator_signed  out  1  to divider numerator_signed.
- div_busy  in  1  from divider busy.
- div_result_valid  in  1  from divider result_valid.
- div_quotient  in  N_BITS  from divider quotient.
- div_remainder  in  N_BITS  from divider remainder.

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready, rsp_valid, div_start = 0; operand, result and grant registers = 0; RR pointer = N_REQ-1, so requester 0 wins first.
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - If any req_valid, grant g = first valid index searching from (ptr+1) mod N_REQ upward, wrapping.
  - req_ready[g]=1 combinationally in the same cycle; the handshake completes that cycle.
  - Latch operands, signed flag and g, then go to ISSUE.
  - No valid: stay in IDLE.
- ISSUE:
  - If div_busy=0, assert div_start for exactly one cycle, then go to WAIT.
  - Otherwise hold, with div_start=0.
  - div_* operand outputs are driven from the latched registers in all states.
- WAIT:
  - On div_result_valid=1, capture div_quotient and div_remainder, then go to RESPOND.
  - The divider clears result_valid on the edge it accepts start, so a stale result_valid cannot be sampled here.
- RESPOND:
  - rsp_valid[g]=1, holding rsp_quotient/rsp_remainder stable until rsp_ready[g]=1.
  - On handshake: ptr = g, go to IDLE.
  - rsp_ready of other requesters is ignored.
- Latency: acceptance cycle to rsp_valid = N_BITS+2 cycles when div_busy is low in ISSUE. This is 10 cycles at N_BITS=8.
- Throughput: one divide in flight; no pipelining.
- Results pass through unmodified. Signed mode negates the quotient only; the remainder is the magnitude remainder, matching the divider.
- Simultaneous events:
  - A request arriving while an operation is in flight waits; req_ready stays 0.
  - A grant never changes mid-operation.
  - req_valid dropping before acceptance is legal.
- Reset mid-operation returns to IDLE immediately. The divider has its own reset; if it is still looping, ISSUE waits for div_busy=0.
- Fairness: any continuously valid requester is served within N_REQ operations.

Optional Feature:
- Macro DIV_ZERO_BYPASS_EN.
- When defined:
  - IDLE detects latched denominator==0 and goes directly to RESPOND without starting the divider.
  - Result is quotient = all ones, remainder = numerator.
  - Adds output rsp_div_zero (1 bit), high alongside rsp_valid for such results; reset 0.
- When undefined: zero denominators go to the divider like any other operand; no rsp_div_zero port exists.

Decomposition:
- Package `divider_pkg`: enum divider_arb_state {IDLE, ISSUE, WAIT, RESPOND}, plus function req_idx_w(n) = max(1, $clog2(n)).
- The arbiter state enum must not reuse the bare names already used by the divider's state type; prefix them (ARB_IDLE, ...).
- Sub-module `rr_arbiter`: parameter N_REQ; inputs valid vector, pointer, enable; outputs one-hot grant and index. Purely combinational priority rotate.

Test Plan:
- N_BITS=8, N_REQ=4: req0 only, 100/7 unsigned -> req_ready[0] same cycle; rsp_valid=0001 with q=14, r=2, 10 cycles later.
- req1 with 0x9C/7 and signed=1 -> q=0xF2 (-14), r=2.
- All four valid continuously with distinct operands -> grant order 0,1,2,3,0; every response correct.
- rsp_ready[2] held low for 5 cycles during RESPOND -> rsp_valid and data stable; no new req_ready.
- rst_n pulsed low in mid-WAIT -> all outputs 0 asynchronously; next request is served correctly after div_busy falls.
- DIV_ZERO_BYPASS_EN defined, 55/0 -> q=0xFF, r=55, rsp_div_zero=1, div_start never asserted. Undefined: the divider is started.

Source files
------------

// File: rtl/divider_arbiter_pkg.sv
// divider_pkg: arbiter FSM state type and index-width helper for divider_arbiter.
package divider_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESPOND} divider_arb_state;
    function automatic int req_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/divider_arbiter_if.sv
// divider_arbiter_if: requester, response and shared-divider signals; rsp_div_zero exists only with DIV_ZERO_BYPASS_EN.
interface divider_arbiter_if #(parameter int N_BITS = 8, parameter int N_REQ = 4);
    logic [N_REQ-1:0]        req_valid, req_ready, req_signed, rsp_valid, rsp_ready;
    logic [N_REQ*N_BITS-1:0] req_numerator, req_denominator;
    logic [N_BITS-1:0]       rsp_quotient, rsp_remainder;
    logic [N_BITS-1:0]       div_numerator, div_denominator, div_quotient, div_remainder;
    logic                    div_start, div_numerator_signed, div_busy, div_result_valid;
`ifdef DIV_ZERO_BYPASS_EN
    logic                    rsp_div_zero;
`endif
    modport slave (
        input  req_valid, req_signed, req_numerator, req_denominator, rsp_ready,
        input  div_busy, div_result_valid, div_quotient, div_remainder,
        output req_ready, rsp_valid, rsp_quotient, rsp_remainder,
        output div_start, div_numerator, div_denominator, div_numerator_signed
`ifdef DIV_ZERO_BYPASS_EN
        , output rsp_div_zero
`endif
    );
    modport master (
        output req_valid, req_signed, req_numerator, req_denominator, rsp_ready,
        output div_busy, div_result_valid, div_quotient, div_remainder,
        input  req_ready, rsp_valid, rsp_quotient, rsp_remainder,
        input  div_start, div_numerator, div_denominator, div_numerator_signed
`ifdef DIV_ZERO_BYPASS_EN
        , input rsp_div_zero
`endif
    );
endinterface

// File: rtl/divider_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr+1 with wrap.
module rr_arbiter
    import divider_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IW = req_idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IW-1:0]    ptr,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx
);
    logic          found;
    logic [IW-1:0] j;
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = IW'((int'(ptr) + k) % N_REQ);
            if (en && !found && valid[j]) begin
                grant[j] = 1'b1;
                idx      = j;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin sharing of one iterative divider among N_REQ requesters.
// Optional DIV_ZERO_BYPASS_EN answers zero-denominator requests without starting the divider.
module divider_arbiter
    import divider_pkg::*;
#(
    parameter int N_BITS = 8,
    parameter int N_REQ  = 4
) (
    input logic               clk,
    input logic               rst_n,
    divider_arbiter_if.slave  bus
);
    localparam int IW = req_idx_w(N_REQ);
    divider_arb_state  state;
    logic [IW-1:0]     ptr, gidx, arb_idx;
    logic [N_REQ-1:0]  arb_grant, rsp_v;
    logic [N_BITS-1:0] num, den, quo, rem;
    logic [N_BITS-1:0] nums [N_REQ];
    logic [N_BITS-1:0] dens [N_REQ];
    logic              sgn;
    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign nums[g] = bus.req_numerator[g*N_BITS +: N_BITS];
        assign dens[g] = bus.req_denominator[g*N_BITS +: N_BITS];
    end
    // grants are suppressed during reset so no handshake can complete unlatched
    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .valid (bus.req_valid),
        .ptr   (ptr),
        .en    (state == ARB_IDLE && rst_n),
        .grant (arb_grant),
        .idx   (arb_idx)
    );
    assign bus.req_ready            = arb_grant;
    assign bus.div_start            = (state == ARB_ISSUE) && !bus.div_busy;
    assign bus.div_numerator        = num;
    assign bus.div_denominator      = den;
    assign bus.div_numerator_signed = sgn;
    assign bus.rsp_valid            = rsp_v;
    assign bus.rsp_quotient         = quo;
    assign bus.rsp_remainder        = rem;
`ifdef DIV_ZERO_BYPASS_EN
    logic dz;
    assign bus.rsp_div_zero = dz;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
            ptr   <= IW'(N_REQ - 1);
            gidx  <= '0;
            num   <= '0;
            den   <= '0;
            sgn   <= 1'b0;
            quo   <= '0;
            rem   <= '0;
            rsp_v <= '0;
`ifdef DIV_ZERO_BYPASS_EN
            dz    <= 1'b0;
`endif
        end else begin
            case (state)
                ARB_IDLE: if (|arb_grant) begin
                    num  <= nums[arb_idx];
                    den  <= dens[arb_idx];
                    sgn  <= bus.req_signed[arb_idx];
                    gidx <= arb_idx;
`ifdef DIV_ZERO_BYPASS_EN
                    if (dens[arb_idx] == '0) begin
                        quo   <= '1;
                        rem   <= nums[arb_idx];
                        rsp_v <= arb_grant;
                        dz    <= 1'b1;
                        state <= ARB_RESPOND;
                    end else
`endif
                    state <= ARB_ISSUE;
                end
                ARB_ISSUE: if (!bus.div_busy) state <= ARB_WAIT;
                ARB_WAIT: if (bus.div_result_valid) begin
                    quo   <= bus.div_quotient;
                    rem   <= bus.div_remainder;
                    rsp_v <= N_REQ'(1) << gidx;
                    state <= ARB_RESPOND;
                end
                ARB_RESPOND: if (bus.rsp_ready[gidx]) begin
                    rsp_v <= '0;
`ifdef DIV_ZERO_BYPASS_EN
                    dz    <= 1'b0;
`endif
                    ptr   <= gidx;
                    state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end
endmodule
